// File: rtl/bist_ctrl.sv
// Logic BIST controller: an LFSR drives patterns into the CUT and a MISR compacts
// the responses. The final signature is compared against a golden value.
module bist_ctrl #(
    parameter int             W         = 8,
    parameter int             SW        = 16,
    parameter int             N_PAT     = 255,
    parameter logic [W-1:0]   LFSR_POLY = 8'hB8,
    parameter logic [W-1:0]   LFSR_SEED = '1,
    parameter logic [SW-1:0]  MISR_POLY = 16'h1021,
    parameter logic [SW-1:0]  MISR_SEED = '0,
    localparam int            CW        = $clog2(N_PAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] golden,
    input  logic [SW-1:0] cut_resp,
    output logic [W-1:0]  pattern,
    output logic [SW-1:0] signature,
    output logic [CW-1:0] pat_cnt,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [W-1:0]  SEED = (LFSR_SEED == '0) ? W'(1) : LFSR_SEED;
    localparam logic [CW-1:0] LAST = CW'(N_PAT - 1);
    localparam logic [CW-1:0] MAXC = CW'(N_PAT);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        CMP,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  lfsr, lfsr_nxt;
    logic [SW-1:0] misr, misr_nxt, misr_step;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pass_q, pass_nxt;

    assign misr_step = ({misr[SW-2:0], 1'b0} ^ (misr[SW-1] ? MISR_POLY : '0)) ^ cut_resp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            lfsr   <= SEED;
            misr   <= MISR_SEED;
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            lfsr   <= lfsr_nxt;
            misr   <= misr_nxt;
            cnt    <= cnt_nxt;
            pass_q <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        misr_nxt  = misr;
        cnt_nxt   = cnt;
        pass_nxt  = pass_q;
        if (abort) begin
            state_nxt = IDLE;
            pass_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state_nxt = INIT;
                end
                INIT: begin
                    lfsr_nxt  = SEED;
                    misr_nxt  = MISR_SEED;
                    cnt_nxt   = '0;
                    pass_nxt  = 1'b0;
                    state_nxt = RUN;
                end
                RUN: begin
                    lfsr_nxt = {lfsr[W-2:0], ^(lfsr & LFSR_POLY)};
                    misr_nxt = misr_step;
                    if (cnt != MAXC) cnt_nxt = cnt + CW'(1);
                    if (cnt == LAST) state_nxt = CMP;
                end
                CMP: begin
                    pass_nxt  = (misr == golden);
                    state_nxt = DONE;
                end
                DONE: begin
                    if (start) state_nxt = INIT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pattern   = lfsr;
    assign signature = misr;
    assign pat_cnt   = cnt;
    assign busy      = (state == INIT) || (state == RUN) || (state == CMP);
    assign done      = (state == DONE);
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Scoreboard bench for bist_ctrl: two instances (7- and 4-pattern runs) with
// expected run records queued by the stimulus and checked when busy drops.
module tb_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic [3:0] golden_a, golden_b;
    logic [3:0] resp = 4'h1;
    logic [2:0] pattern_a, pattern_b, cnt_a, cnt_b;
    logic [3:0] sig_a, sig_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

    int n_chk  = 0;
    int n_pass = 0;
    int lat_a  = 0;
    int lat_b  = 0;

    typedef struct packed {
        bit              done;
        int              len;
        int              npat;
        logic [7:0][2:0] pat;
        int              nsig;
        logic [7:0][3:0] sig;
        bit              fin;
        logic [3:0]      fsig;
        int              fcnt;
        bit              fpass;
        logic [2:0]      fpat;
        int              lat;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];

    always #5 clk = ~clk;

    bist_ctrl #(
        .W(3), .SW(4), .N_PAT(7), .LFSR_POLY(3'b110), .LFSR_SEED(3'b111),
        .MISR_POLY(4'h3), .MISR_SEED(4'h0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .golden(golden_a), .cut_resp(resp), .pattern(pattern_a),
        .signature(sig_a), .pat_cnt(cnt_a), .busy(busy_a), .done(done_a),
        .pass(pass_a)
    );

    bist_ctrl #(
        .W(3), .SW(4), .N_PAT(4), .LFSR_POLY(3'b110), .LFSR_SEED(3'b111),
        .MISR_POLY(4'h3), .MISR_SEED(4'h0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .golden(golden_b), .cut_resp(resp), .pattern(pattern_b),
        .signature(sig_b), .pat_cnt(cnt_b), .busy(busy_b), .done(done_b),
        .pass(pass_b)
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // Hand-computed: LFSR 7,6,4,1,2,5,3; MISR with resp=1: 1,3,7,F,C,A,6.
    function automatic rec_t run_a(input bit p);
        rec_t r = '0;
        r.done = 1; r.len = 9; r.npat = 7; r.nsig = 7;
        r.pat = {3'd0, 3'd3, 3'd5, 3'd2, 3'd1, 3'd4, 3'd6, 3'd7};
        r.sig = {4'h0, 4'h6, 4'hA, 4'hC, 4'hF, 4'h7, 4'h3, 4'h1};
        r.fin = 1; r.fsig = 4'h6; r.fcnt = 7; r.fpass = p; r.fpat = 3'd7;
        r.lat = 9;
        return r;
    endfunction

    function automatic rec_t run_b(input bit p);
        rec_t r = '0;
        r.done = 1; r.len = 6; r.npat = 4; r.nsig = 4;
        r.pat = {12'd0, 3'd1, 3'd4, 3'd6, 3'd7};
        r.sig = {16'd0, 4'hF, 4'h7, 4'h3, 4'h1};
        r.fin = 1; r.fsig = 4'hF; r.fcnt = 4; r.fpass = p; r.fpat = 3'd2;
        r.lat = 6;
        return r;
    endfunction

    function automatic rec_t cut_a(input int len, input int npat, input bit rst);
        rec_t r = '0;
        r.done = 0; r.len = len; r.npat = npat; r.nsig = 0;
        r.pat = {3'd0, 3'd3, 3'd5, 3'd2, 3'd1, 3'd4, 3'd6, 3'd7};
        r.fin = rst; r.fsig = 4'h0; r.fcnt = 0; r.fpass = 0; r.fpat = 3'd7;
        r.lat = -1;
        return r;
    endfunction

    task automatic ev(input string nm, input rec_t r, input logic [2:0] tp[$],
                      input logic [3:0] ts[$], input logic d, input logic [2:0] p,
                      input logic [3:0] s, input logic [2:0] c, input logic ps,
                      input int lat);
        chk({nm, "_len"}, tp.size(), r.len);
        chk({nm, "_done"}, d, r.done);
        for (int i = 0; i < r.npat; i++)
            chk($sformatf("%s_pat%0d", nm, i), tp[i+1], r.pat[i]);
        for (int i = 0; i < r.nsig; i++)
            chk($sformatf("%s_sig%0d", nm, i), ts[i+2], r.sig[i]);
        if (r.fin) begin
            chk({nm, "_signature"}, s, r.fsig);
            chk({nm, "_pat_cnt"}, c, r.fcnt);
            chk({nm, "_pass"}, ps, r.fpass);
            chk({nm, "_pattern"}, p, r.fpat);
        end
        if (r.lat >= 0) chk({nm, "_latency"}, lat, r.lat);
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) lat_a = 0;
        else if (start_a && !abort_a && !busy_a) lat_a = 0;
        else lat_a++;
        if (!rst_n) lat_b = 0;
        else if (start_b && !abort_b && !busy_b) lat_b = 0;
        else lat_b++;
    end

    // Monitor A: collect per-cycle trace while busy, score when busy drops.
    initial begin
        logic [2:0] tp[$];
        logic [3:0] ts[$];
        logic       prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_a === 1'b1) begin
                tp.push_back(pattern_a);
                ts.push_back(sig_a);
            end else if (prev) begin
                if (qa.size() == 0) chk("a_unexpected_run", 1, 0);
                else ev("a", qa.pop_front(), tp, ts, done_a, pattern_a, sig_a,
                        cnt_a, pass_a, lat_a);
                tp.delete();
                ts.delete();
            end
            prev = (busy_a === 1'b1);
        end
    end

    initial begin
        logic [2:0] tp[$];
        logic [3:0] ts[$];
        logic       prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_b === 1'b1) begin
                tp.push_back(pattern_b);
                ts.push_back(sig_b);
            end else if (prev) begin
                if (qb.size() == 0) chk("b_unexpected_run", 1, 0);
                else ev("b", qb.pop_front(), tp, ts, done_b, pattern_b, sig_b,
                        cnt_b, pass_b, lat_b);
                tp.delete();
                ts.delete();
            end
            prev = (busy_b === 1'b1);
        end
    end

    task automatic pulse(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((b ? done_b : done_a) === 1'b1) return;
        end
        chk(b ? "b_done_timeout" : "a_done_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b1; start_b = 1'b1;
        abort_a = 1'b0; abort_b = 1'b0;
        golden_a = 4'h6; golden_b = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_sig", sig_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_pattern", pattern_a, 7);
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_done", done_b, 0);

        // start held high for the whole run must not restart it
        qa.push_back(run_a(1));
        @(negedge clk);
        start_a = 1'b1;
        wait_done(0);
        start_a = 1'b0;
        @(negedge clk);
        chk("hold_done", done_a, 1);
        chk("hold_pass", pass_a, 1);
        chk("hold_cnt", cnt_a, 7);

        qa.push_back(run_a(1));
        pulse(0);
        chk("restart_busy", busy_a, 1);
        chk("restart_done", done_a, 0);
        wait_done(0);

        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_done_done", done_a, 0);
        chk("abort_done_pass", pass_a, 0);
        chk("abort_done_busy", busy_a, 0);

        qa.push_back(cut_a(5, 4, 0));
        pulse(0);
        repeat (4) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_run_busy", busy_a, 0);
        chk("abort_run_done", done_a, 0);

        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("idle_abort_start", busy_a, 0);
        @(negedge clk);
        chk("idle_abort_start2", busy_a, 0);

        qa.push_back(run_a(1));
        pulse(0);
        wait_done(0);

        qa.push_back(cut_a(4, 3, 1));
        pulse(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_done", done_a, 0);

        qa.push_back(run_a(1));
        pulse(0);
        wait_done(0);

        golden_b = 4'hF;
        qb.push_back(run_b(1));
        pulse(1);
        wait_done(1);
        golden_b = 4'hE;
        qb.push_back(run_b(0));
        pulse(1);
        wait_done(1);
        @(negedge clk);
        chk("b_fail_pass", pass_b, 0);
        chk("b_fail_done", done_b, 1);

        repeat (3) @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
